// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported fixed-latency RAM between instruction fetch and the
// data stage; formats RISC-V byte/half/word stores and sign/zero-extends loads.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        mem_rwtype,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              mem_fault,
  output logic              mem_stall,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  typedef enum logic {OWN_IF, OWN_MEM} owner_e;

  state_e             state_q;
  owner_e             owner_q;
  logic               we_q;
  logic [2:0]         rwtype_q;
  logic [1:0]         off_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ram_en_q, if_ready_q, mem_ready_q, mem_fault_q;
  logic [3:0]         ram_we_q;
  logic [ADDR_W-1:0]  ram_addr_q;
  logic [31:0]        ram_wdata_q, if_rdata_q, mem_rdata_q;

  logic               fault_d;
  logic [3:0]         ram_we_d;
  logic [31:0]        ram_wdata_d;
  logic [31:0]        shifted;
  logic [31:0]        load_d;

  // Fetch addresses are always word aligned; the low bits are deliberately dropped.
  logic unused_if_lsbs;
  assign unused_if_lsbs = ^if_addr[1:0];

  // Request decode for the data port: fault detection, byte strobes, lane shift.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    fault_d     = 1'b0;
    ram_we_d    = 4'b0000;
    ram_wdata_d = mem_wdata << {mem_addr[1:0], 3'b000};
    case (mem_rwtype)
      3'b000:         ram_we_d = 4'b0001 << mem_addr[1:0];
      3'b001, 3'b101: begin
        ram_we_d = 4'b0011 << mem_addr[1:0];
        fault_d  = mem_addr[0] | (mem_we & mem_rwtype[2]);
      end
      3'b010: begin
        ram_we_d = 4'b1111;
        fault_d  = (mem_addr[1:0] != 2'b00);
      end
      3'b100:  fault_d = mem_we;
      default: fault_d = 1'b1;
    endcase
  end

  // Load extension works on the live RAM word, selected by the latched offset.
  always_comb begin
    shifted = ram_rdata >> {off_q, 3'b000};
    load_d  = shifted;
    case (rwtype_q)
      3'b000:  load_d = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_d = {24'h0, shifted[7:0]};
      3'b001:  load_d = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_d = {16'h0, shifted[15:0]};
      default: load_d = shifted;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      rwtype_q    <= 3'b000;
      off_q       <= 2'b00;
      cnt_q       <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'b0000;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'b0000;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_req) begin
            owner_q  <= OWN_MEM;
            we_q     <= mem_we;
            rwtype_q <= mem_rwtype;
            off_q    <= mem_addr[1:0];
            if (fault_d) begin
              state_q     <= DONE;
              mem_ready_q <= 1'b1;
              mem_fault_q <= 1'b1;
              mem_rdata_q <= '0;
            end else begin
              state_q    <= ISSUE;
              ram_en_q   <= 1'b1;
              ram_addr_q <= {mem_addr[ADDR_W-1:2], 2'b00};
              if (mem_we) begin
                ram_we_q    <= ram_we_d;
                ram_wdata_q <= ram_wdata_d;
              end
            end
          end else if (if_req) begin
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            state_q    <= ISSUE;
            ram_en_q   <= 1'b1;
            ram_addr_q <= {if_addr[ADDR_W-1:2], 2'b00};
          end
        end
        ISSUE: begin
          if (we_q) begin
            state_q     <= DONE;
            mem_ready_q <= 1'b1;
          end else begin
            state_q <= WAIT;
            cnt_q   <= CNT_W'(LAT - 1);
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            if (owner_q == OWN_IF) begin
              if_ready_q <= 1'b1;
              if_rdata_q <= ram_rdata;
            end else begin
              mem_ready_q <= 1'b1;
              mem_rdata_q <= load_d;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        // Always leave DONE so a request still held from this access is not re-granted.
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_fault = mem_fault_q;
  assign if_stall  = if_req & ~if_ready_q;
  assign mem_stall = mem_req & ~mem_ready_q;

endmodule
